// File: rtl/gpr_wr_arbiter_pkg.sv
// gpr_wr_arbiter_pkg: shared widths, write-enable polarity, arbiter defaults,
// FSM state encoding and the queued-entry layout for the GPR write arbiter.
package gpr_wr_arbiter_pkg;

  localparam int unsigned REG_ADDR_W  = 5;   // REG_ADDR_BUS  = [4:0]
  localparam int unsigned WORD_DATA_W = 32;  // WORD_DATA_BUS = [31:0]

  // Active-low write enables
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Arbiter defaults
  localparam int unsigned GPR_ARB_DEPTH  = 2;
  localparam int unsigned GPR_ARB_STARVE = 4;

  // 1-bit state encoding, values kept identical to the legacy macros
  typedef enum logic [0:0] {
    GPR_ARB_NORMAL = 1'b0,
    GPR_ARB_FORCE  = 1'b1
  } gpr_arb_state_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]  addr;
    logic [WORD_DATA_W-1:0] data;
  } gpr_wr_ent_t;

endpackage

// File: rtl/gpr_wr_fifo.sv
// gpr_wr_fifo: DEPTH-entry {addr,data} FIFO holding long-latency results
// waiting for a free GPR write slot.
// Ports:
//   clk, reset      clock, synchronous active-low reset (empties the FIFO)
//   push, push_ent  enqueue request and entry (ignored when full)
//   pop             dequeue head (ignored when empty)
//   full, empty     occupancy flags
//   head            current head entry
//   ent_valid       per-slot valid flags (slot index = storage index)
//   ent_addr        per-slot destination addresses
module gpr_wr_fifo
  import gpr_wr_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = GPR_ARB_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  gpr_wr_ent_t                      push_ent,
  input  logic                             pop,
  output logic                             full,
  output logic                             empty,
  output gpr_wr_ent_t                      head,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  gpr_wr_ent_t   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [PW-1:0] offs;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers are log2(DEPTH) bits, so increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_ent;
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    ent_valid = '0;
    ent_addr  = '0;
    offs      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs         = PW'(i) - rd_ptr;
      ent_valid[i] = ({1'b0, offs} < count);
      ent_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/gpr_wr_arbiter.sv
// gpr_wr_arbiter: shares the single GPR write port between the WB stage
// (always first, never back-pressured) and the long-latency unit, whose
// results queue in gpr_wr_fifo and drain into idle WB slots. A head that
// waits STARVE_LIMIT cycles moves the FSM to FORCE, which requests a WB
// bubble until the head is written. pend_* flag queued destinations.
// Ports:
//   clk, reset                      clock, synchronous active-low reset
//   wb_we_, wb_addr, wb_data        WB write request (active-low enable)
//   lu_valid, lu_ready              LU result handshake
//   lu_addr, lu_data                LU result destination/data
//   chk_addr_0/1, pend_0/1          decode pending-destination check
//   wb_stall                        bubble request to the pipeline
//   gpr_we_, gpr_wr_addr/data       GPR write port (active-low enable)
module gpr_wr_arbiter
  import gpr_wr_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = GPR_ARB_DEPTH,
  parameter int unsigned STARVE_LIMIT = GPR_ARB_STARVE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_we_,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  input  logic [WORD_DATA_W-1:0] wb_data,
  input  logic                   lu_valid,
  output logic                   lu_ready,
  input  logic [REG_ADDR_W-1:0]  lu_addr,
  input  logic [WORD_DATA_W-1:0] lu_data,
  input  logic [REG_ADDR_W-1:0]  chk_addr_0,
  input  logic [REG_ADDR_W-1:0]  chk_addr_1,
  output logic                   pend_0,
  output logic                   pend_1,
  output logic                   wb_stall,
  output logic                   gpr_we_,
  output logic [REG_ADDR_W-1:0]  gpr_wr_addr,
  output logic [WORD_DATA_W-1:0] gpr_wr_data
);

  localparam int unsigned AW = $clog2(STARVE_LIMIT + 1);

  gpr_arb_state_e                   state;
  logic [AW-1:0]                    age;
  logic                             wb_act;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             push;
  logic                             pop;
  gpr_wr_ent_t                      head;
  gpr_wr_ent_t                      push_ent;
  logic [DEPTH-1:0]                 ent_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] ent_addr;
  logic                             hit_0;
  logic                             hit_1;

  assign wb_act   = (wb_we_ == ENABLE_);
  assign lu_ready = reset & ~fifo_full;
  // r0 writes are dropped: accepted from the LU but never queued.
  assign push     = lu_valid & lu_ready & (lu_addr != '0);
  assign pop      = reset & ~wb_act & ~fifo_empty;
  assign push_ent = '{addr: lu_addr, data: lu_data};

  gpr_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_ent  (push_ent),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  // Write-port mux: WB first, then the FIFO head, else idle.
  always_comb begin
    gpr_we_     = DISABLE_;
    gpr_wr_addr = '0;
    gpr_wr_data = '0;
    if (reset) begin
      if (wb_act) begin
        gpr_we_     = ENABLE_;
        gpr_wr_addr = wb_addr;
        gpr_wr_data = wb_data;
      end else if (!fifo_empty) begin
        gpr_we_     = ENABLE_;
        gpr_wr_addr = head.addr;
        gpr_wr_data = head.data;
      end
    end
  end

  // Age counts cycles the head has waited; state and age share one register stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= GPR_ARB_NORMAL;
      age   <= '0;
    end else begin
      if (pop || fifo_empty)              age <= '0;
      else if (age != AW'(STARVE_LIMIT))  age <= age + 1'b1;

      case (state)
        GPR_ARB_NORMAL: if (age == AW'(STARVE_LIMIT)) state <= GPR_ARB_FORCE;
        GPR_ARB_FORCE:  if (pop)                      state <= GPR_ARB_NORMAL;
        default:                                      state <= GPR_ARB_NORMAL;
      endcase
    end
  end

  assign wb_stall = reset & (state == GPR_ARB_FORCE);

  // Includes the head being drained this cycle, so the check is conservative.
  always_comb begin
    hit_0 = 1'b0;
    hit_1 = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_addr[i] == chk_addr_0) hit_0 = 1'b1;
      if (ent_valid[i] && ent_addr[i] == chk_addr_1) hit_1 = 1'b1;
    end
  end

  assign pend_0 = reset & (chk_addr_0 != '0) & hit_0;
  assign pend_1 = reset & (chk_addr_1 != '0) & hit_1;

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// tb_gpr_wr_arbiter: directed scenarios followed by random traffic, each
// cycle compared against a queue-based reference model of the arbiter.
module tb_gpr_wr_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        wb_we_;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic [4:0]  chk_addr_0;
  logic [4:0]  chk_addr_1;
  logic        pend_0;
  logic        pend_1;
  logic        wb_stall;
  logic        gpr_we_;
  logic [4:0]  gpr_wr_addr;
  logic [31:0] gpr_wr_data;

  gpr_wr_arbiter #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_we_      (wb_we_),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_addr     (lu_addr),
    .lu_data     (lu_data),
    .chk_addr_0  (chk_addr_0),
    .chk_addr_1  (chk_addr_1),
    .pend_0      (pend_0),
    .pend_1      (pend_1),
    .wb_stall    (wb_stall),
    .gpr_we_     (gpr_we_),
    .gpr_wr_addr (gpr_wr_addr),
    .gpr_wr_data (gpr_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: queued {addr,data}, head wait time, bubble request.
  logic [36:0] q[$];
  int          waited;
  bit          forced;

  int n_pass;
  int n_total;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input logic rst, input logic wbw, input logic [4:0] wa,
                      input logic [31:0] wd, input logic lv, input logic [4:0] la,
                      input logic [31:0] ld, input logic [4:0] c0, input logic [4:0] c1);
    logic        e_we, e_rdy, e_st, e_p0, e_p1;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    bit          do_pop, do_push, was_busy;
    reset = rst; wb_we_ = wbw; wb_addr = wa; wb_data = wd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
    chk_addr_0 = c0; chk_addr_1 = c1;

    e_we = 1'b1; e_a = '0; e_d = '0; e_rdy = 1'b0; e_st = 1'b0; e_p0 = 1'b0; e_p1 = 1'b0;
    if (rst) begin
      e_rdy = (q.size() < DEPTH);
      e_st  = forced;
      if (!wbw) begin
        e_we = 1'b0; e_a = wa; e_d = wd;
      end else if (q.size() > 0) begin
        e_we = 1'b0; e_a = q[0][36:32]; e_d = q[0][31:0];
      end
      foreach (q[i]) begin
        if (c0 != 0 && q[i][36:32] == c0) e_p0 = 1'b1;
        if (c1 != 0 && q[i][36:32] == c1) e_p1 = 1'b1;
      end
    end

    @(negedge clk);
    check("gpr_we_",     gpr_we_,     e_we);
    check("gpr_wr_addr", gpr_wr_addr, e_a);
    check("gpr_wr_data", gpr_wr_data, e_d);
    check("lu_ready",    lu_ready,    e_rdy);
    check("wb_stall",    wb_stall,    e_st);
    check("pend_0",      pend_0,      e_p0);
    check("pend_1",      pend_1,      e_p1);

    @(posedge clk);
    if (!rst) begin
      q.delete();
      waited = 0;
      forced = 0;
    end else begin
      was_busy = (q.size() > 0);
      do_pop   = wbw && was_busy;
      do_push  = lv && (q.size() < DEPTH) && (la != 0);
      if (forced && do_pop)             forced = 0;
      else if (!forced && waited == LIMIT) forced = 1;
      if (do_pop || !was_busy)          waited = 0;
      else if (waited < LIMIT)          waited++;
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back({la, ld});
    end
    #1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; waited = 0; forced = 0;
    reset = 0; wb_we_ = 1; wb_addr = 0; wb_data = 0;
    lu_valid = 0; lu_addr = 0; lu_data = 0; chk_addr_0 = 0; chk_addr_1 = 0;
    @(posedge clk); #1;

    // Reset state
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 3, 32'h1, 1, 3, 32'h2, 3, 3);

    // 1: WB only
    step(1, 0, 5, 32'hA5A5_A5A5, 0, 0, 0, 5, 0);

    // 2: LU drain with pend check around the pop
    step(1, 1, 0, 0, 1, 7, 32'h11, 7, 0);
    step(1, 1, 0, 0, 0, 0, 0, 7, 0);
    step(1, 1, 0, 0, 0, 0, 0, 7, 0);

    // 3: full / back-pressure, in-order drain
    step(1, 0, 1, 32'hB1, 1, 3, 32'h33, 3, 4);
    step(1, 0, 1, 32'hB2, 1, 4, 32'h44, 3, 4);
    step(1, 0, 1, 32'hB3, 1, 6, 32'h66, 6, 4);
    step(1, 1, 0, 0,      1, 6, 32'h66, 6, 3);
    step(1, 0, 2, 32'hB4, 1, 6, 32'h66, 6, 4);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, 4, 6);

    // 4: starvation with one queued entry behind continuous WB writes
    step(1, 0, 2, 32'hC0, 1, 9, 32'h99, 9, 0);
    for (int i = 1; i < 8; i++) step(1, 0, 2, 32'hC0 + i, 0, 0, 0, 9, 0);
    step(1, 1, 0, 0, 0, 0, 0, 9, 0);
    step(1, 0, 2, 32'hCF, 0, 0, 0, 9, 0);

    // 5: push to r0 is consumed but never queued
    step(1, 1, 0, 0, 1, 0, 32'hDEAD, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // 6: reset while in FORCE with the FIFO full
    step(1, 0, 1, 32'hE1, 1, 10, 32'hAA, 10, 11);
    step(1, 0, 1, 32'hE2, 1, 11, 32'hBB, 10, 11);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 32'hE3, 0, 0, 0, 10, 11);
    step(0, 0, 1, 32'hE4, 1, 12, 32'hCC, 10, 11);
    step(1, 1, 0, 0, 0, 0, 0, 10, 11);
    step(1, 1, 0, 0, 0, 0, 0, 10, 11);

    // Random traffic, mostly busy WB to exercise starvation and back-pressure
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0),
           ($urandom_range(0, 9) < 3),
           5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
